pipe_reg_elastic: RTL
=====================

Name: pipe_reg_elastic

Overview:
Parametrised, handshaked pipeline latch that replaces the fixed-field en/flush stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque WIDTH-bit payload, typically a packed per-stage struct. It adds valid/ready flow control, an optional skid slot for full throughput under backpressure, occupancy reporting and a saturating stall counter. It sits between any two pipeline stages and is driven by the global hit-based freeze (en) and the hazard unit's flush.

Parameters:
WIDTH, 256, payload bits (set to the $bits of the stage payload struct)
SKID, 1, 1 = two-entry elastic (main + skid slot); 0 = single register, in_ready depends combinationally on out_ready
CNT_W, 16, stall counter width

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous, active-low reset
en  input  1  global advance enable; 0 freezes all state
flush  input  1  synchronous squash of stage contents
in_valid  input  1  upstream payload valid
in_ready  output  1  block accepts payload this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  main slot holds valid payload (registered)
out_ready  input  1  downstream accepts
out_data  output  WIDTH  main slot payload (registered)
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  cycles with out_valid=1, out_ready=0, en=1

Behaviour:
- Reset (nRST=0, async): state EMPTY; main and skid payloads all-zero; out_valid=0; out_data=0; occupancy=0; stall_cnt=0.
- Fire definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & en.
- in_ready (combinational):
  - SKID=1: en & !flush & (state != SKID_FULL).
  - SKID=0: en & !flush & (!out_valid | out_ready).
- States (enum EMPTY, FULL, SKID_FULL); SKID_FULL is reachable only when SKID=1.
  - EMPTY: in_fire -> FULL, main<=in_data.
  - FULL:
    - in_fire & out_fire -> FULL, main<=in_data.
    - in_fire & !out_fire -> SKID_FULL, skid<=in_data (SKID=1 only).
    - !in_fire & out_fire -> EMPTY, main<=0.
    - otherwise hold.
  - SKID_FULL: out_fire -> FULL, main<=skid, skid<=0; otherwise hold.
- Zero-bubble rule: main payload is all-zero whenever out_valid=0, so a bubble is a NOP (instr=0) with all control bits 0.
- Latency: 1 cycle from in_fire to out_valid. Throughput is 1/cycle under continuous out_ready, for both SKID settings.
- en=0: no state, payload or counter changes; in_ready=0; out_valid/out_data hold; out_fire cannot occur.
- flush=1: at the next edge, regardless of en, state->EMPTY and both payloads cleared. in_ready is forced 0, so a same-cycle input is dropped. flush overrides any simultaneous in_fire/out_fire bookkeeping. stall_cnt is not cleared.
- occupancy: EMPTY=0, FULL=1, SKID_FULL=2, registered with state.
- stall_cnt: +1 per cycle with out_valid & !out_ready & en & !flush. Saturates at 2^CNT_W-1 and never wraps. Cleared only by nRST.
- nRST asserted mid-transfer: immediate clear, and any in-flight payload is lost by design.

Decomposition:
- Shared package pipe_pkg:
  - pstate_t enum (EMPTY, FULL, SKID_FULL).
  - Packed payload structs ifid_payload_t, idex_payload_t, exmem_payload_t, memwb_payload_t; instantiators set WIDTH=$bits(struct).
  - Localparam NOP_PAYLOAD='0.
- One natural sub-module: sat_counter (parameter W, inputs CLK/nRST/inc, output count), used for stall_cnt.

Test Plan:
- Reset/idle: nRST=0 with in_valid=1, in_data=0xDEAD -> out_valid=0, out_data=0, occupancy=0, stall_cnt=0. After release with en=1: in_ready=1.
- Streaming (SKID=1 and SKID=0): out_ready=1, in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, back-to-back, occupancy=1, stall_cnt=0.
- Backpressure SKID=1: hold 0xA, out_ready=0, present 0xB -> 0xB accepted, occupancy=2, in_ready=0. Hold 3 more cycles -> stall_cnt=4. Raise out_ready -> 0xA then 0xB, no loss or duplicate.
- Flush in SKID_FULL: flush=1 for one cycle with in_valid=1, in_data=0xC -> next cycle occupancy=0, out_valid=0, out_data=0, 0xC never appears. stall_cnt retains its value.
- Freeze: FULL with 0x5, en=0 for 4 cycles, in_valid=1, out_ready=1 -> in_ready=0; out_data=0x5, occupancy and stall_cnt unchanged. en=1 -> 0x5 consumed next edge.
- SKID=0, CNT_W=4: FULL, out_ready=0 -> in_ready=0 same cycle. 20 stall cycles -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage latches: occupancy state and the
// per-stage payload structs that set WIDTH via $bits().
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } pstate_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_payload_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_payload_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_payload_t;

  // Replicated to WIDTH by users; an all-zero payload decodes as a NOP.
  localparam logic NOP_PAYLOAD = 1'b0;

endpackage

// File: rtl/pipe_reg_elastic_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Generic handshaked pipeline stage latch with optional skid slot,
// occupancy reporting and a saturating backpressure stall counter.
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WIDTH-1:0] NOP_WORD = {WIDTH{NOP_PAYLOAD}};

  pstate_t          state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             in_fire, out_fire;

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign occupancy = state_reg;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = en & ~flush & (state_reg != SKID_FULL);
    end else begin : g_noskid
      assign in_ready = en & ~flush & (~out_valid | out_ready);
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & en;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
      main_next  = NOP_WORD;
      skid_next  = NOP_WORD;
    end else if (en) begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            state_next = FULL;
            main_next  = in_data;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_next = SKID_FULL;
            skid_next  = in_data;
          end else if (out_fire) begin
            // Drain to a zero bubble so downstream sees a clean NOP.
            state_next = EMPTY;
            main_next  = NOP_WORD;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            state_next = FULL;
            main_next  = skid_reg;
            skid_next  = NOP_WORD;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = NOP_WORD;
          skid_next  = NOP_WORD;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (out_valid & ~out_ready & en & ~flush),
    .count (stall_cnt)
  );

endmodule
